// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative multiply/divide sequencer for the EX-stage ALU.
//                Executes MUL, MULH(U), DIV(U), REM(U) with one shift-add or
//                restoring-divide step per cycle, stalling the pipeline while
//                busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 6,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            is_unsigned,
    input  logic            flush,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_op;
    logic                r_sa;
    logic                r_sb;
    logic                r_dz;
    logic [XLEN-1:0]     r_opnd;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_acc;       // {hi/rem, lo/multiplier/quotient}

    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic                w_early;
    logic [XLEN-1:0]     w_special_res;

    logic [XLEN-1:0]     w_addend;
    logic [XLEN:0]       w_msum;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_new;
    logic [2*XLEN-1:0]   w_acc_step;

    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    // Operand conditioning at acceptance: magnitudes, signs and special cases
    always_comb begin
        w_accept      = (r_state == S_IDLE) && start && !flush;
        w_sa          = !is_unsigned && operand_a[XLEN-1];
        w_sb          = !is_unsigned && operand_b[XLEN-1];
        w_abs_a       = w_sa ? -operand_a : operand_a;
        w_abs_b       = w_sb ? -operand_b : operand_b;
        w_b_zero      = (operand_b == '0);
        // Most-negative dividend over -1 cannot be represented as a quotient
        w_ovf         = w_sa && (operand_a[XLEN-2:0] == '0) && (&operand_b);
        w_special     = op[1] && (w_b_zero || w_ovf);
        w_early       = (EARLY_OUT != 0) && w_special;
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = op[0] ? operand_a : '1;
        end else if (w_ovf) begin
            w_special_res = op[0] ? '0 : operand_a;
        end
    end

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        w_addend   = r_acc[0] ? r_opnd : '0;
        w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
        w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_opnd};
        w_ge       = (w_shift >= {1'b0, r_opnd});
        w_rem_new  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        w_acc_step = {w_msum, r_acc[XLEN-1:1]};
        if (r_op[1]) begin
            w_acc_step = {w_rem_new, r_acc[XLEN-2:0], w_ge};
        end
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo     = r_acc[XLEN-1:0];
        w_rem     = r_acc[2*XLEN-1:XLEN];
        w_fix_res = '0;
        case (r_op)
            2'b00:   w_fix_res = w_prod[XLEN-1:0];
            2'b01:   w_fix_res = w_prod[2*XLEN-1:XLEN];
            2'b10:   w_fix_res = r_dz ? '1 : ((r_sa ^ r_sb) ? -w_quo : w_quo);
            default: w_fix_res = r_sa ? -w_rem : w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_early ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    // Datapath: latch operands at acceptance, iterate in RUN, register in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_dz   <= 1'b0;
            r_opnd <= '0;
            r_acc  <= '0;
            result <= '0;
        end else if (w_accept) begin
            r_cnt  <= c_cnt_init;
            r_op   <= op;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_dz   <= w_b_zero;
            if (op[1]) begin
                r_opnd <= w_abs_b;
                r_acc  <= {{XLEN{1'b0}}, w_abs_a};
            end else begin
                r_opnd <= w_abs_a;
                r_acc  <= {{XLEN{1'b0}}, w_abs_b};
            end
            if (w_early) begin
                result <= w_special_res;
            end
        end else if ((r_state == S_RUN) && !flush) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - c_cnt_one;
        end else if ((r_state == S_FIX) && !flush) begin
            result <= w_fix_res;
        end
    end

    // Status outputs; stall drops combinationally on flush
    always_comb begin
        busy  = (r_state == S_RUN) || (r_state == S_FIX);
        done  = (r_state == S_DONE);
        stall = w_accept || (busy && !flush);
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer: table of directed
//                vectors plus flush, back-to-back and async-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        is_unsigned = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6), .EARLY_OUT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .is_unsigned (is_unsigned),
        .flush       (flush),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble operands after E0, and time the done pulse
    task automatic run_op(input string name, input logic [1:0] o, input logic u,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        @(negedge clk);
        op = o; is_unsigned = u; operand_a = a; operand_b = b; start = 1'b1;
        #1 stalls = stall ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        lat = 0;
        res = '0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (stall) stalls++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
        @(negedge clk);
        check({name, " done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] prev;
        int lat, stalls, d1, d2, ndone;

        vecs[0]  = '{"mul_s_7x-3",     2'b00, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
        vecs[1]  = '{"mulhu_max",      2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
        vecs[2]  = '{"mulh_s_-1x-1",   2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT};
        vecs[3]  = '{"div_s_-7/2",     2'b10, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT};
        vecs[4]  = '{"rem_s_-7%2",     2'b11, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT};
        vecs[5]  = '{"divu",           2'b10, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, LAT};
        vecs[6]  = '{"div_by_zero",    2'b10, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{"rem_ovf",        2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[8]  = '{"div_ovf",        2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{"remu_100%7",     2'b11, 1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, LAT};
        vecs[10] = '{"mulhu_2^32",     2'b01, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT};
        vecs[11] = '{"mul_lo_2^32",    2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, LAT};
        vecs[12] = '{"rem_s_7%-2",     2'b11, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT};
        vecs[13] = '{"div_s_7/-2",     2'b10, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT};
        vecs[14] = '{"rem_by_zero",    2'b11, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 1};
        vecs[15] = '{"divu_no_ovf",    2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT};
        vecs[16] = '{"mul_s_-1x-1",    2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT};
        vecs[17] = '{"divu_by_zero",   2'b10, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[18] = '{"mulh_s_neg",     2'b01, 1'b0, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, LAT};

        // Reset state
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", {28'd0, stall, busy, done, result}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {28'd0, stall, busy, done, result}, 64'd0);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, res, lat, stalls);
            check({vecs[i].name, " result"}, {32'd0, res}, {32'd0, vecs[i].exp});
            check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, " stall_cycles"}, 64'(stalls), 64'(vecs[i].lat));
        end
        prev = vecs[18].exp;

        // Flush at cycle 10 of RUN
        @(negedge clk);
        op = 2'b00; is_unsigned = 1'b0; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 10; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        flush = 1'b1;
        #1 check("flush_stall_comb", {63'd0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_no_done", 64'(ndone + (done ? 1 : 0)), 64'd0);
        check("flush_result_held", {32'd0, result}, {32'd0, prev});
        run_op("after_flush", 2'b00, 1'b0, 32'd9, 32'd11, res, lat, stalls);
        check("after_flush result", {32'd0, res}, 64'd99);
        check("after_flush latency", 64'(lat), 64'(LAT));

        // Back-to-back with start held high
        @(negedge clk);
        op = 2'b00; is_unsigned = 1'b0; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
        @(posedge clk);
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b result", {32'd0, result}, 64'd42);
                if (d1 == 0) begin
                    d1 = k;
                end else begin
                    d2 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b first_latency", 64'(d1), 64'(LAT));
        check("b2b spacing", 64'(d2 - d1), 64'd35);
        @(negedge clk);

        // Async reset at cycle 5 of RUN
        @(negedge clk);
        op = 2'b10; is_unsigned = 1'b0; operand_a = 32'd100; operand_b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {28'd0, stall, busy, done, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("reset_no_done", 64'(ndone), 64'd0);
        run_op("after_reset", 2'b10, 1'b0, 32'd100, 32'd3, res, lat, stalls);
        check("after_reset result", {32'd0, res}, 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
